// File: rtl/led_status_ctrl_if.sv
// Status bus between the vending FSM and the front-panel LED driver.
// The FSM side owns the master modport and the LED driver owns the slave modport.
interface led_status_ctrl_if #(
    parameter int N_LED   = 16,
    parameter int GOODS_W = 3,
    parameter int NUM_W   = 2,
    parameter int MONEY_W = 5,
    parameter int PWM_W   = 8
);
    logic [5:0]         state;
    logic [GOODS_W-1:0] in_goods_high;
    logic [GOODS_W-1:0] in_goods_low;
    logic [NUM_W-1:0]   in_goods_num;
    logic [MONEY_W-1:0] money;
    logic [PWM_W-1:0]   rgb_duty;
    logic [N_LED-1:0]   led_btn;
    logic               rgb1_red;
    logic               rgb1_green;
    logic               rgb1_blue;
    logic               state_err;

    modport master (
        output state, in_goods_high, in_goods_low, in_goods_num, money, rgb_duty,
        input  led_btn, rgb1_red, rgb1_green, rgb1_blue, state_err
    );

    modport slave (
        input  state, in_goods_high, in_goods_low, in_goods_num, money, rgb_duty,
        output led_btn, rgb1_red, rgb1_green, rgb1_blue, state_err
    );
endinterface

// File: rtl/led_status_ctrl.sv
// Front-panel LED/RGB driver: blinking, RGB PWM and illegal-state detection, all outputs registered.
// Define LED_PAYMENT_BAR_EN to show PAYMENT as a thermometer bar instead of the binary money field.
module led_status_ctrl #(
    parameter int N_LED     = 16,
    parameter int GOODS_W   = 3,
    parameter int NUM_W     = 2,
    parameter int MONEY_W   = 5,
    parameter int BLINK_DIV = 25_000_000,
    parameter int PWM_W     = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    led_status_ctrl_if.slave bus
);
    localparam int CNT_W      = $clog2(BLINK_DIV);
    localparam int GOODS_BITS = 2 * GOODS_W + NUM_W;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'h01,
        ST_GOODS_ONE = 6'h02,
        ST_GOODS_TWO = 6'h04,
        ST_PAYMENT   = 6'h08,
        ST_CHANGE    = 6'h10,
        ST_TEMP      = 6'h20
    } state_e;

    logic [5:0]       state_q;
    logic [CNT_W-1:0] blink_cnt;
    logic [CNT_W-1:0] blink_cnt_nxt;
    logic             blink_ph;
    logic             blink_ph_nxt;
    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_on;
    logic             state_legal;
    logic [N_LED-1:0] led_nxt;
    logic [2:0]       colour;

    // A state change restarts the half-period lit, and takes priority over the terminal count.
    always_comb begin
        blink_cnt_nxt = blink_cnt + CNT_W'(1);
        blink_ph_nxt  = blink_ph;
        if (bus.state != state_q) begin
            blink_cnt_nxt = '0;
            blink_ph_nxt  = 1'b1;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_nxt = '0;
            blink_ph_nxt  = ~blink_ph;
        end
    end

    assign pwm_on      = (&bus.rgb_duty) | (pwm_cnt < bus.rgb_duty);
    assign state_legal = (bus.state != '0) && ((bus.state & (bus.state - 6'd1)) == '0);

    // Outputs use the upcoming blink phase so a fresh CHANGE entry is lit on its first cycle.
    always_comb begin
        led_nxt = '0;
        colour  = 3'b000;
        if (!state_legal) begin
            colour = {blink_ph_nxt, 2'b00};
        end else begin
            case (state_e'(bus.state))
                ST_IDLE: colour = 3'b000;
                ST_GOODS_ONE: begin
                    led_nxt[GOODS_BITS-1:0] = {bus.in_goods_num, bus.in_goods_high, bus.in_goods_low};
                    colour                  = 3'b100;
                end
                ST_GOODS_TWO: begin
                    led_nxt[GOODS_BITS-1:0] = {bus.in_goods_num, bus.in_goods_high, bus.in_goods_low};
                    colour                  = 3'b010;
                end
                ST_PAYMENT: begin
`ifdef LED_PAYMENT_BAR_EN
                    for (int i = 0; i < N_LED; i++) begin
                        led_nxt[i] = (i < int'(bus.money));
                    end
`else
                    led_nxt                    = '1;
                    led_nxt[N_LED-1 -: MONEY_W] = bus.money;
`endif
                    colour = 3'b001;
                end
                ST_CHANGE: begin
                    led_nxt = {N_LED{blink_ph_nxt}};
                    colour  = 3'b011;
                end
                ST_TEMP: begin
                    led_nxt = '1;
                    colour  = 3'b111;
                end
                default: colour = 3'b000;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.led_btn    <= '0;
            bus.rgb1_red   <= 1'b0;
            bus.rgb1_green <= 1'b0;
            bus.rgb1_blue  <= 1'b0;
            bus.state_err  <= 1'b0;
            blink_cnt      <= '0;
            blink_ph       <= 1'b1;
            pwm_cnt        <= '0;
            state_q        <= '0;
        end else begin
            bus.led_btn    <= led_nxt;
            bus.rgb1_red   <= colour[2] & pwm_on;
            bus.rgb1_green <= colour[1] & pwm_on;
            bus.rgb1_blue  <= colour[0] & pwm_on;
            bus.state_err  <= ~state_legal;
            blink_cnt      <= blink_cnt_nxt;
            blink_ph       <= blink_ph_nxt;
            pwm_cnt        <= pwm_cnt + PWM_W'(1);
            state_q        <= bus.state;
        end
    end
endmodule
